// File: rtl/core_pkg.sv
// Shared core types: LSU operation encoding, LSU controller states and defaults.
package core_pkg;

    typedef enum logic [3:0] {
        LSU_NONE_OP                 = 4'd0,
        LSU_LOAD_BYTE               = 4'd1,
        LSU_LOAD_BYTE_UNSIGNED      = 4'd2,
        LSU_LOAD_HALF_WORD          = 4'd3,
        LSU_LOAD_HALF_WORD_UNSIGNED = 4'd4,
        LSU_LOAD_WORD               = 4'd5,
        LSU_STORE_BYTE              = 4'd6,
        LSU_STORE_HALF_WORD         = 4'd7,
        LSU_STORE_WORD              = 4'd8
    } lsu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } lsu_state_t;

    localparam int unsigned LSU_TIMEOUT_DEFAULT = 255;

    function automatic logic lsu_is_store(lsu_op_t op);
        return op inside {LSU_STORE_BYTE, LSU_STORE_HALF_WORD, LSU_STORE_WORD};
    endfunction

endpackage

// File: rtl/lsu_data_align.sv
// Combinational lane logic: byte enables, store replication, load extraction, alignment.
module lsu_data_align
    import core_pkg::*;
(
    input  lsu_op_t     i_op,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata,
    output logic        o_misaligned
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_rdata[{i_addr_lo, 3'b000} +: 8];
    assign w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

    // Decode access size into enables, replicated store data and extended load data
    always_comb begin
        o_be         = 4'b0000;
        o_wdata      = i_wdata;
        o_rdata      = '0;
        o_misaligned = 1'b0;
        case (i_op)
            LSU_LOAD_BYTE, LSU_LOAD_BYTE_UNSIGNED, LSU_STORE_BYTE: begin
                o_be    = 4'b0001 << i_addr_lo;
                o_wdata = {4{i_wdata[7:0]}};
                o_rdata = (i_op == LSU_LOAD_BYTE) ? {{24{w_byte[7]}}, w_byte} : {24'h0, w_byte};
            end
            LSU_LOAD_HALF_WORD, LSU_LOAD_HALF_WORD_UNSIGNED, LSU_STORE_HALF_WORD: begin
                o_be         = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_wdata      = {2{i_wdata[15:0]}};
                o_rdata      = (i_op == LSU_LOAD_HALF_WORD) ? {{16{w_half[15]}}, w_half}
                                                            : {16'h0, w_half};
                o_misaligned = i_addr_lo[0];
            end
            LSU_LOAD_WORD, LSU_STORE_WORD: begin
                o_be         = 4'b1111;
                o_rdata      = i_rdata;
                o_misaligned = |i_addr_lo;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// LSU controller: accepts one op, runs the req/gnt/rvalid bus handshake, reports done.
module lsu_ctrl
    import core_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = LSU_TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        op_valid,
    input  lsu_op_t     op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic        misaligned,
    output logic        bus_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam logic [7:0] TimeoutLim = 8'(TIMEOUT_CYCLES);

    lsu_state_t  r_state;
    lsu_op_t     r_op;
    logic [1:0]  r_addr_lo;
    logic [7:0]  r_cnt;

    lsu_op_t     w_sel_op;
    logic [1:0]  w_sel_addr_lo;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_rdata;
    logic        w_misaligned;
    logic [7:0]  w_cnt_inc;
    logic        w_timeout;

    // In IDLE the aligner looks at the incoming op; afterwards at the latched one
    assign w_sel_op      = (r_state == IDLE) ? op : r_op;
    assign w_sel_addr_lo = (r_state == IDLE) ? addr[1:0] : r_addr_lo;
    assign w_cnt_inc     = r_cnt + 8'd1;
    assign w_timeout     = (w_cnt_inc == TimeoutLim);

    lsu_data_align u_align (
        .i_op         (w_sel_op),
        .i_addr_lo    (w_sel_addr_lo),
        .i_wdata      (wdata),
        .i_rdata      (mem_rdata),
        .o_be         (w_be),
        .o_wdata      (w_wdata),
        .o_rdata      (w_rdata),
        .o_misaligned (w_misaligned)
    );

    // FSM with registered bus and completion outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_op       <= LSU_NONE_OP;
            r_addr_lo  <= '0;
            r_cnt      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            rdata      <= '0;
            misaligned <= 1'b0;
            bus_err    <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_be     <= '0;
            mem_wdata  <= '0;
        end else begin
            done       <= 1'b0;
            misaligned <= 1'b0;
            bus_err    <= 1'b0;
            rdata      <= '0;
            case (r_state)
                IDLE: begin
                    if (op_valid && (op != LSU_NONE_OP)) begin
                        busy <= 1'b1;
                        if (w_misaligned) begin
                            r_state    <= DONE;
                            done       <= 1'b1;
                            misaligned <= 1'b1;
                        end else begin
                            r_state   <= REQ;
                            r_op      <= op;
                            r_addr_lo <= addr[1:0];
                            r_cnt     <= '0;
                            mem_req   <= 1'b1;
                            mem_we    <= lsu_is_store(op);
                            mem_addr  <= {addr[31:2], 2'b00};
                            mem_be    <= w_be;
                            mem_wdata <= w_wdata;
                        end
                    end
                end
                REQ: begin
                    r_cnt <= w_cnt_inc;
                    if (w_timeout || mem_gnt) begin
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_addr  <= '0;
                        mem_be    <= '0;
                        mem_wdata <= '0;
                    end
                    // The limit wins over a grant arriving in the same cycle
                    if (w_timeout) begin
                        r_state <= DONE;
                        done    <= 1'b1;
                        bus_err <= 1'b1;
                    end else if (mem_gnt) begin
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    r_cnt <= w_cnt_inc;
                    if (w_timeout) begin
                        r_state <= DONE;
                        done    <= 1'b1;
                        bus_err <= 1'b1;
                    end else if (mem_rvalid) begin
                        r_state <= DONE;
                        done    <= 1'b1;
                        rdata   <= lsu_is_store(r_op) ? 32'h0 : w_rdata;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: random ops against a behavioural model, plus timeout/reset.
module tb_lsu_ctrl;
    import core_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    // Main DUT (default timeout)
    logic        rst_n, op_valid;
    lsu_op_t     op;
    logic [31:0] addr, wdata;
    logic        busy, done, misaligned, bus_err, mem_req, mem_we;
    logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic        mem_gnt, mem_rvalid;

    lsu_ctrl dut (
        .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op(op), .addr(addr), .wdata(wdata),
        .busy(busy), .done(done), .rdata(rdata), .misaligned(misaligned), .bus_err(bus_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata)
    );

    // Second DUT with a short timeout for timeout and reset scenarios
    logic        rst_n_t, op_valid_t;
    lsu_op_t     op_t;
    logic [31:0] addr_t, wdata_t;
    logic        busy_t, done_t, misaligned_t, bus_err_t, mem_req_t, mem_we_t;
    logic [31:0] rdata_t, mem_addr_t, mem_wdata_t, rdata_in_t;
    logic [3:0]  mem_be_t;
    logic        gnt_t, rvalid_t;

    lsu_ctrl #(.TIMEOUT_CYCLES(4)) dut_t (
        .clk(clk), .rst_n(rst_n_t), .op_valid(op_valid_t), .op(op_t), .addr(addr_t),
        .wdata(wdata_t), .busy(busy_t), .done(done_t), .rdata(rdata_t),
        .misaligned(misaligned_t), .bus_err(bus_err_t), .mem_req(mem_req_t),
        .mem_we(mem_we_t), .mem_addr(mem_addr_t), .mem_be(mem_be_t), .mem_wdata(mem_wdata_t),
        .mem_gnt(gnt_t), .mem_rvalid(rvalid_t), .mem_rdata(rdata_in_t)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] word;
        int          gd;
        int          rd;
    } bus_exp_t;

    typedef struct {
        logic [31:0] rdata;
        logic        mis;
        int          t_acc;
        int          lat;
    } resp_exp_t;

    bus_exp_t  bus_q[$];
    resp_exp_t resp_q[$];

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model helpers
    function automatic int op_size(lsu_op_t o);
        case (o)
            LSU_LOAD_BYTE, LSU_LOAD_BYTE_UNSIGNED, LSU_STORE_BYTE: return 1;
            LSU_LOAD_HALF_WORD, LSU_LOAD_HALF_WORD_UNSIGNED, LSU_STORE_HALF_WORD: return 2;
            default: return 4;
        endcase
    endfunction

    function automatic bit op_store(lsu_op_t o);
        return (o == LSU_STORE_BYTE) || (o == LSU_STORE_HALF_WORD) || (o == LSU_STORE_WORD);
    endfunction

    function automatic bit op_signed(lsu_op_t o);
        return (o == LSU_LOAD_BYTE) || (o == LSU_LOAD_HALF_WORD);
    endfunction

    task automatic issue(lsu_op_t o, logic [31:0] a, logic [31:0] wd, logic [31:0] word,
                         int gd, int rd);
        int        sz;
        int        sh;
        bit        mis;
        int        guard;
        logic [63:0] v, m;
        bus_exp_t  b;
        resp_exp_t r;
        sz  = op_size(o);
        sh  = 8 * int'(a[1:0]);
        mis = (int'(a[1:0]) % sz) != 0;
        // Junk requests while busy must be ignored
        guard = 0;
        while (busy && guard < 100) begin
            op_valid = 1'($urandom_range(0, 1));
            op       = lsu_op_t'(4'($urandom_range(1, 8)));
            addr     = $urandom;
            @(posedge clk);
            #1;
            guard++;
        end
        if (busy) check("idle_wait", busy, 1'b0);
        op_valid = 1'b1;
        op       = o;
        addr     = a;
        wdata    = wd;
        v = {32'h0, word} >> sh;
        m = (64'd1 << (8 * sz)) - 64'd1;
        v = v & m;
        if (op_signed(o) && v[8 * sz - 1]) v = v | ~m;
        r.rdata = (mis || op_store(o)) ? 32'h0 : v[31:0];
        r.mis   = mis;
        r.t_acc = cyc;
        r.lat   = mis ? 1 : 3 + gd + rd;
        resp_q.push_back(r);
        if (!mis) begin
            b.we    = op_store(o);
            b.addr  = a - 32'(int'(a[1:0]));
            b.be    = 4'(((1 << sz) - 1) << int'(a[1:0]));
            b.wdata = (sz == 1) ? wd[7:0] * 32'h01010101 :
                      (sz == 2) ? wd[15:0] * 32'h00010001 : wd;
            b.word  = word;
            b.gd    = gd;
            b.rd    = rd;
            bus_q.push_back(b);
        end
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        op       = LSU_NONE_OP;
        addr     = $urandom;
        wdata    = $urandom;
    endtask

    // Bus responder: checks each request and returns gnt/rvalid after the planned delays
    initial begin : responder
        bus_exp_t b;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        forever begin
            @(negedge clk);
            mem_rvalid = 1'b0;
            if (rst_n && mem_req) begin
                if (bus_q.size() == 0) begin
                    check("unexpected_req", mem_req, 1'b0);
                end else begin
                    b = bus_q.pop_front();
                    check("req_we", mem_we, b.we);
                    check("req_addr", mem_addr, b.addr);
                    check("req_be", mem_be, b.be);
                    check("req_wdata", mem_wdata, b.wdata);
                    for (int i = 0; i < b.gd; i++) begin
                        @(negedge clk);
                        check("req_held", mem_req, 1'b1);
                        check("req_stable_addr", mem_addr, b.addr);
                        check("req_stable_be", mem_be, b.be);
                        check("req_stable_wdata", mem_wdata, b.wdata);
                    end
                    mem_gnt = 1'b1;
                    @(negedge clk);
                    mem_gnt = 1'b0;
                    check("req_drop", mem_req, 1'b0);
                    for (int i = 0; i < b.rd; i++) @(negedge clk);
                    mem_rvalid = 1'b1;
                    mem_rdata  = b.word;
                    @(negedge clk);
                    mem_rvalid = 1'b0;
                    mem_rdata  = $urandom;
                    check("done_after_rvalid", done, 1'b1);
                end
            end else if ($urandom_range(0, 7) == 0) begin
                // Spurious response outside WAIT
                mem_rvalid = 1'b1;
                mem_rdata  = $urandom;
            end
        end
    end

    // Completion monitor
    always @(negedge clk) begin : monitor
        resp_exp_t r;
        if (rst_n && done) begin
            if (resp_q.size() == 0) begin
                check("unexpected_done", done, 1'b0);
            end else begin
                r = resp_q.pop_front();
                check("rdata", rdata, r.rdata);
                check("misaligned", misaligned, r.mis);
                check("bus_err", bus_err, 1'b0);
                check("latency", cyc - r.t_acc, r.lat);
                check("busy_at_done", busy, 1'b1);
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int n_req, n_done, done_at;
        logic err_cap, mis_cap;
        logic [31:0] rd_cap;
        lsu_op_t ro;
        rst_n = 1'b1; rst_n_t = 1'b1;
        op_valid = 1'b0; op = LSU_NONE_OP; addr = '0; wdata = '0;
        op_valid_t = 1'b0; op_t = LSU_NONE_OP; addr_t = '0; wdata_t = '0;
        gnt_t = 1'b0; rvalid_t = 1'b0; rdata_in_t = '0;
        #1;
        rst_n = 1'b0; rst_n_t = 1'b0;
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_flags", {misaligned, bus_err}, 2'b00);
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_mem_bus", {mem_we, mem_be}, 5'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1; rst_n_t = 1'b1;
        @(posedge clk);
        #1;

        // Directed cases
        issue(LSU_STORE_BYTE, 32'h0000_1003, 32'h0000_00A5, $urandom, 0, 0);
        issue(LSU_LOAD_BYTE, 32'h0000_2002, $urandom, 32'h0080_0000, 0, 0);
        issue(LSU_LOAD_BYTE_UNSIGNED, 32'h0000_2002, $urandom, 32'h0080_0000, 1, 1);
        issue(LSU_LOAD_HALF_WORD, 32'h0000_3001, $urandom, $urandom, 0, 0);
        issue(LSU_LOAD_WORD, 32'h0000_4000, $urandom, 32'hDEAD_BEEF, 3, 2);
        issue(LSU_STORE_HALF_WORD, 32'h0000_5002, 32'h1234_ABCD, $urandom, 0, 1);
        issue(LSU_LOAD_HALF_WORD, 32'h0000_6002, $urandom, 32'h8001_7FFF, 2, 0);

        // Random ops
        for (int n = 0; n < 200; n++) begin
            ro = lsu_op_t'(4'($urandom_range(1, 8)));
            issue(ro, $urandom, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 2));
        end
        for (int i = 0; i < 60 && (resp_q.size() != 0 || bus_q.size() != 0); i++)
            @(posedge clk);
        check("drain_resp", resp_q.size(), 0);
        check("drain_bus", bus_q.size(), 0);

        // Timeout with grant withheld, then a late response
        @(posedge clk);
        #1;
        op_valid_t = 1'b1; op_t = LSU_LOAD_WORD; addr_t = 32'h40;
        @(posedge clk);
        #1;
        op_valid_t = 1'b0; op_t = LSU_NONE_OP;
        n_req = 0; n_done = 0; done_at = -1;
        err_cap = 1'b0; mis_cap = 1'b1; rd_cap = 32'hFFFF_FFFF;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            rvalid_t   = (i == 5);
            rdata_in_t = 32'hCAFE_F00D;
            if (mem_req_t) n_req++;
            if (done_t) begin
                n_done++;
                if (done_at < 0) begin
                    done_at = i;
                    err_cap = bus_err_t;
                    mis_cap = misaligned_t;
                    rd_cap  = rdata_t;
                end
            end
        end
        rvalid_t = 1'b0;
        check("to_req_cycles", n_req, 4);
        check("to_done_cycle", done_at, 4);
        check("to_bus_err", err_cap, 1'b1);
        check("to_misaligned", mis_cap, 1'b0);
        check("to_rdata", rd_cap, 32'h0);
        check("to_done_count", n_done, 1);
        check("to_idle", busy_t, 1'b0);

        // Reset while in WAIT
        @(posedge clk);
        #1;
        op_valid_t = 1'b1; op_t = LSU_LOAD_WORD; addr_t = 32'h80;
        @(posedge clk);
        #1;
        op_valid_t = 1'b0; op_t = LSU_NONE_OP;
        @(negedge clk);
        gnt_t = 1'b1;
        @(negedge clk);
        gnt_t = 1'b0;
        check("rw_busy_before", busy_t, 1'b1);
        #1;
        rst_n_t = 1'b0;
        #1;
        check("rw_busy", busy_t, 1'b0);
        check("rw_req", mem_req_t, 1'b0);
        check("rw_done", done_t, 1'b0);
        check("rw_bus", {mem_we_t, mem_be_t}, 5'h0);
        check("rw_addr", mem_addr_t, 32'h0);
        check("rw_wdata", mem_wdata_t, 32'h0);
        #2;
        rst_n_t = 1'b1;
        @(negedge clk);
        rvalid_t = 1'b1; rdata_in_t = 32'h1234_5678;
        n_done = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            rvalid_t = 1'b0;
            if (done_t) n_done++;
        end
        check("rw_no_done", n_done, 0);

        // Next op after reset completes normally
        @(posedge clk);
        #1;
        op_valid_t = 1'b1; op_t = LSU_LOAD_HALF_WORD_UNSIGNED; addr_t = 32'h86;
        @(posedge clk);
        #1;
        op_valid_t = 1'b0; op_t = LSU_NONE_OP;
        @(negedge clk);
        check("ra_req", mem_req_t, 1'b1);
        check("ra_addr", mem_addr_t, 32'h84);
        check("ra_be", mem_be_t, 4'b1100);
        gnt_t = 1'b1;
        @(negedge clk);
        gnt_t = 1'b0;
        rvalid_t = 1'b1; rdata_in_t = 32'hBEEF_1234;
        @(negedge clk);
        rvalid_t = 1'b0;
        check("ra_done", done_t, 1'b1);
        check("ra_rdata", rdata_t, 32'h0000_BEEF);

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store unit controller for the RV32I core. It accepts one `lsu_op_t` operation from the execute stage and drives the data-memory bus through a req/gnt/rvalid handshake. It generates byte enables and lane-replicated store data, and extracts and sign/zero-extends load data. It signals misaligned accesses and bus timeouts back to the core, and the core stalls on it until `done`.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 255: cycles spent in REQ+WAIT before the access is aborted with `bus_err`; range 1..255.

Ports:
- Clocking: one clock; reset is asynchronous and active-low.
- `clk` in 1: core clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `op_valid` in 1: the execute stage presents an LSU operation.
- `op` in 4 (`lsu_op_t`): operation; `LSU_NONE_OP` is never accepted.
- `addr` in 32: byte address (ALU result).
- `wdata` in 32: store data (rs2).
- `busy` out 1: high whenever the controller is not in IDLE.
- `done` out 1: one-cycle completion pulse.
- `rdata` out 32: extended load result; valid when `done`=1; 0 for stores and errors.
- `misaligned` out 1: qualifies `done`; the access was misaligned and no bus transaction occurred.
- `bus_err` out 1: qualifies `done`; the access timed out.
- `mem_req` out 1: bus request.
- `mem_we` out 1: 1 for a store.
- `mem_addr` out 32: word-aligned address `{addr[31:2],2'b00}`.
- `mem_be` out 4: byte enables.
- `mem_wdata` out 32: lane-replicated store data.
- `mem_gnt` in 1: the bus accepted the request.
- `mem_rvalid` in 1: response valid; returned for loads and stores alike.
- `mem_rdata` in 32: load word.

## Operation
- States: IDLE, REQ, WAIT, DONE.
- IDLE → REQ: `op_valid`=1, `op`≠`LSU_NONE_OP`, access aligned.
  - Latch op, addr and wdata.
  - Clear the timeout counter.
- IDLE → DONE with `misaligned`=1 when the access is misaligned:
  - half-word load or store with addr[0]=1;
  - word load or store with addr[1:0]≠0.
- REQ → WAIT when `mem_gnt`=1.
- WAIT → DONE on `mem_rvalid`=1.
  - Loads capture the extracted data into `rdata`.
- REQ or WAIT → DONE with `bus_err`=1 when the counter reaches `TIMEOUT_CYCLES`.
- DONE → IDLE unconditionally. `op_valid` is ignored while in DONE.
- Byte enables:
  - byte: `4'b0001<<addr[1:0]`;
  - half: `0011` for addr[1]=0, `1100` for addr[1]=1;
  - word: `1111`;
  - loads use the same enables.
- Store data: byte replicated ×4; half replicated ×2; word as-is.
- Load data:
  - Select the byte lane addr[1:0] or half lane addr[1].
  - `LSU_LOAD_BYTE` and `LSU_LOAD_HALF_WORD` sign-extend.
  - The `_UNSIGNED` variants zero-extend.
- The `mem_*` outputs are registered and held stable while `mem_req`=1.
- `mem_req` is 0 in every state except REQ.
- `mem_rvalid` outside WAIT (late or spurious) is ignored.
- `mem_gnt` outside REQ is ignored.

## Timing
- Reset value of every output is 0; state is IDLE; the counter is 0.
- Best-case load or store:
  - accept at cycle T;
  - `mem_req`=1 at T+1, `mem_gnt` at T+1;
  - `mem_rvalid` at T+2;
  - `done` at T+3;
  - next accept at T+4.
- `mem_rvalid` is never asserted in the same cycle as `mem_gnt`. The bus guarantees this.
- Misaligned access: accept at T, `done`+`misaligned` at T+1, zero bus activity.
- Timeout: the counter increments each cycle in REQ or WAIT. At the count of `TIMEOUT_CYCLES`:
  - `mem_req` drops;
  - `done`+`bus_err` follow on the next cycle.
- Reset mid-operation: `mem_req` and `busy` clear asynchronously, no `done` is issued, and any in-flight response is dropped.
- `busy`=1 from T+1 through the DONE cycle inclusive.

## Structure
- `core_pkg` (existing):
  - reuse `lsu_op_t`;
  - add `lsu_state_t` (IDLE, REQ, WAIT, DONE);
  - add constant `LSU_TIMEOUT_DEFAULT = 255`.
- Sub-module `lsu_data_align` (combinational):
  - inputs: op and addr[1:0];
  - outputs: `mem_be`, replicated store data, extended load data, misaligned flag.
- `lsu_ctrl` holds the FSM, timeout counter and output registers.

## Test plan
- `LSU_STORE_BYTE`, addr `0x1003`, wdata `0xA5` → `mem_addr` `0x1000`, `mem_be` `1000`, `mem_wdata` `0xA5A5A5A5`, `mem_we`=1; `done` 1 cycle after `rvalid`.
- `LSU_LOAD_BYTE` at `0x2002`, `mem_rdata` `0x00800000` → `rdata` `0xFFFFFF80`. Repeat with `LSU_LOAD_BYTE_UNSIGNED` → `0x00000080`.
- `LSU_LOAD_HALF_WORD` at `0x3001` → `done`+`misaligned` at T+1; `mem_req` never asserted.
- `mem_gnt` withheld with `TIMEOUT_CYCLES`=4 → `mem_req` high 4 cycles, then `done`+`bus_err`, `rdata`=0; a late `mem_rvalid` is ignored.
- `LSU_LOAD_WORD` with 3 cycles of `gnt` stall and 2 cycles of `rvalid` delay → `mem_*` stable throughout; `rdata`=`mem_rdata`; `done` asserted exactly once.
- `rst_n` pulsed low while in WAIT → all outputs 0 immediately; no `done`; the next op completes normally.
